ram_byte_streamer: RTL and testbench

//  Reader for the bytewise packet RAM: on a start request, fetches W-bit words over the RAM port
//  and serialises them into a valid/ready byte stream (e.g. UDP TX payload toward the framer).

---
 rtl/ram_streamer_pkg.sv | 29 ++
 rtl/ram_byte_streamer.sv | 165 ++++++++++++++++
 tb/tb_ram_byte_streamer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_streamer_pkg.sv
// Shared types and helpers for the packet-RAM byte streamer: FSM state encoding,
// byte selection within a RAM word, and the byte-length to word-count conversion.
package ram_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM,
        DONE
    } state_e;

    // Widest RAM row the helpers accept; narrower words are zero-extended by the caller.
    localparam int unsigned MAX_W = 512;

    function automatic logic [7:0] byte_sel(input logic [MAX_W-1:0] word,
                                            input int unsigned idx,
                                            input int unsigned nbytes,
                                            input logic big_endian);
        int unsigned k;
        k = big_endian ? (nbytes - 1 - idx) : idx;
        return 8'(word >> (k * 8));
    endfunction

    function automatic int unsigned words_for_len(input int unsigned len,
                                                  input int unsigned nbytes);
        return (len + nbytes - 1) / nbytes;
    endfunction

endpackage

// File: rtl/ram_byte_streamer.sv
// Reads a byte buffer from the packet RAM and serialises it onto a valid/ready byte stream.
// Define RAM_STREAMER_BIG_ENDIAN_EN to emit each word most-significant byte first.
module ram_byte_streamer
    import ram_streamer_pkg::*;
#(
    parameter int W     = 32,
    parameter int L     = 375,
    parameter int LEN_W = 16,
    localparam int AW   = $clog2(L)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [AW-1:0]    start_addr,
    input  logic [LEN_W-1:0] start_len,
    output logic [AW-1:0]    ram_addr,
    output logic             ram_rd_ena,
    input  logic [W-1:0]     ram_rd_data,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   C         = W / 8;
    localparam int            IW        = (C > 1) ? $clog2(C) : 1;
    localparam logic [IW-1:0] IDX_LAST  = IW'(C - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(L - 1);
`ifdef RAM_STREAMER_BIG_ENDIAN_EN
    localparam logic BIG_ENDIAN = 1'b1;
`else
    localparam logic BIG_ENDIAN = 1'b0;
`endif

    state_e           state_q;
    logic             start_ready_q;
    logic             busy_q;
    logic             done_q;
    logic [AW-1:0]    ram_addr_q;
    logic             ram_rd_ena_q;
    logic             rd_pend_q;
    logic [LEN_W-1:0] words_left_q;
    logic [LEN_W-1:0] bytes_left_q;
    logic [W-1:0]     cur_q;
    logic [W-1:0]     nxt_q;
    logic [1:0]       cnt_q;
    logic [IW-1:0]    idx_q;

    logic             accept;
    logic             hs;
    logic             pop;
    logic             last_hs;
    logic             issue;
    logic [2:0]       occ;
    logic [AW-1:0]    addr_d;

    assign accept  = start_valid && start_ready_q;
    assign m_valid = (cnt_q != 2'd0);
    assign hs      = m_valid && m_ready;
    assign last_hs = hs && (bytes_left_q == LEN_W'(1));
    assign pop     = hs && ((idx_q == IDX_LAST) || (bytes_left_q == LEN_W'(1)));

    // Slots already committed: held words plus reads on the RAM port or returning now.
    assign occ     = 3'(cnt_q) + 3'(ram_rd_ena_q) + 3'(rd_pend_q);
    assign issue   = (words_left_q != '0) && (occ <= 3'd1 + 3'(pop));
    assign addr_d  = (ram_addr_q == ADDR_LAST) ? '0 : ram_addr_q + AW'(1);

    assign m_last      = m_valid && (bytes_left_q == LEN_W'(1));
    assign m_data      = byte_sel(MAX_W'(cur_q), 32'(idx_q), C, BIG_ENDIAN);
    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ram_addr    = ram_addr_q;
    assign ram_rd_ena  = ram_rd_ena_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ram_addr_q    <= '0;
            ram_rd_ena_q  <= 1'b0;
            rd_pend_q     <= 1'b0;
            words_left_q  <= '0;
            bytes_left_q  <= '0;
            cur_q         <= '0;
            nxt_q         <= '0;
            cnt_q         <= 2'd0;
            idx_q         <= '0;
        end else begin
            done_q       <= 1'b0;
            ram_rd_ena_q <= 1'b0;
            rd_pend_q    <= ram_rd_ena_q;

            case (state_q)
                IDLE: begin
                    start_ready_q <= 1'b1;
                    if (accept) begin
                        start_ready_q <= 1'b0;
                        bytes_left_q  <= start_len;
                        idx_q         <= '0;
                        if (start_len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= FETCH;
                            busy_q       <= 1'b1;
                            ram_addr_q   <= start_addr;
                            ram_rd_ena_q <= 1'b1;
                            words_left_q <= LEN_W'(words_for_len(32'(start_len), C) - 1);
                        end
                    end
                end
                FETCH, STREAM: begin
                    if (issue) begin
                        ram_addr_q   <= addr_d;
                        ram_rd_ena_q <= 1'b1;
                        words_left_q <= words_left_q - LEN_W'(1);
                    end
                    if ((state_q == FETCH) && rd_pend_q) begin
                        state_q <= STREAM;
                    end
                    if (last_hs) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q       <= IDLE;
                    start_ready_q <= 1'b1;
                end
            endcase

            if (hs) begin
                bytes_left_q <= bytes_left_q - LEN_W'(1);
                idx_q        <= pop ? '0 : idx_q + IW'(1);
            end

            // A capture can coincide with a pop only when a single word is held.
            case ({pop, rd_pend_q})
                2'b01: begin
                    if (cnt_q == 2'd0) begin
                        cur_q <= ram_rd_data;
                        cnt_q <= 2'd1;
                    end else begin
                        nxt_q <= ram_rd_data;
                        cnt_q <= 2'd2;
                    end
                end
                2'b10: begin
                    cur_q <= nxt_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: cur_q <= ram_rd_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_byte_streamer.sv
// Scoreboard bench for ram_byte_streamer: a byte-level reference model fills expectation
// queues at each accepted request; a negedge monitor checks RAM reads and stream bytes.
module tb_ram_byte_streamer;

    localparam int W     = 32;
    localparam int L     = 375;
    localparam int LEN_W = 16;
    localparam int AW    = $clog2(L);
    localparam int C     = W / 8;
`ifdef RAM_STREAMER_BIG_ENDIAN_EN
    localparam bit BIG = 1'b1;
`else
    localparam bit BIG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [AW-1:0]    start_addr = '0;
    logic [LEN_W-1:0] start_len = '0;
    logic [AW-1:0]    ram_addr;
    logic             ram_rd_ena;
    logic [W-1:0]     ram_rd_data = '0;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic             m_last;
    logic             busy;
    logic             done;

    ram_byte_streamer #(.W(W), .L(L), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_addr(start_addr), .start_len(start_len),
        .ram_addr(ram_addr), .ram_rd_ena(ram_rd_ena), .ram_rd_data(ram_rd_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t          exp_q[$];
    int            addr_q[$];
    logic [W-1:0]  mem [L];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            done_seen = 0;
    int            rd_seen = 0;
    int            first_vld = -1;
    int            first_hs = -1;
    int            last_hs = -1;
    int            hs_xfer = 0;
    int            acc_cyc = 0;
    int            done_base = 0;
    int            ready_mode = 0;
    int            phase = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_rd_ena) ram_rd_data <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string msg);
        n_vec++;
        n_err++;
        $display("FAIL %s", msg);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (phase % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            phase++;
        end
    end

    // Monitor: RAM reads against the expected address list, bytes against the byte list.
    initial begin
        logic       stall_pend = 1'b0;
        logic [7:0] held_data = '0;
        logic       held_last = 1'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_pend = 1'b0;
            end else begin
                if (ram_rd_ena) begin
                    rd_seen++;
                    if (addr_q.size() == 0) fail_now($sformatf("unexpected_read: ram_addr=%0d, none expected", ram_addr));
                    else check("ram_addr", 64'(ram_addr), 64'(addr_q.pop_front()));
                end
                if (m_valid && first_vld < 0) first_vld = cyc;
                if (stall_pend) begin
                    check("stall_valid", 64'(m_valid), 64'(1));
                    check("stall_data", 64'(m_data), 64'(held_data));
                    check("stall_last", 64'(m_last), 64'(held_last));
                end
                stall_pend = m_valid && !m_ready;
                held_data  = m_data;
                held_last  = m_last;
                if (m_valid && m_ready) begin
                    hs_xfer++;
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                    if (exp_q.size() == 0) begin
                        fail_now($sformatf("extra_byte: got 0x%0h, none expected", m_data));
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", 64'(m_data), 64'(e.data));
                        check("m_last", 64'(m_last), 64'(e.last));
                    end
                end
                if (done) done_seen++;
            end
        end
    end

    task automatic start_xfer(input int addr, input int len);
        int t = 0;
        logic [W-1:0] wd;
        int k;
        while (!start_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!start_ready) fail_now("start_ready_timeout: start_ready stayed 0, expected 1");
        done_base   = done_seen;
        start_valid = 1'b1;
        start_addr  = AW'(addr);
        start_len   = LEN_W'(len);
        @(posedge clk);
        for (int w = 0; w < (len + C - 1) / C; w++) addr_q.push_back((addr + w) % L);
        for (int i = 0; i < len; i++) begin
            wd = mem[(addr + i / C) % L];
            k  = BIG ? (C - 1 - i % C) : (i % C);
            exp_q.push_back('{data: 8'(wd >> (8 * k)), last: (i == len - 1)});
        end
        #1;
        start_valid = 1'b0;
        acc_cyc   = cyc;
        first_vld = -1;
        first_hs  = -1;
        last_hs   = -1;
        hs_xfer   = 0;
        check("accept_ready_low", 64'(start_ready), 64'(0));
        check("accept_rd_ena", 64'(ram_rd_ena), 64'(len != 0));
        check("accept_busy", 64'(busy), 64'(len != 0));
    endtask

    task automatic wait_done(input int bound);
        int t = 0;
        while (done_seen == done_base && t < bound) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (done_seen == done_base) fail_now("done_timeout: no done pulse within bound");
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("done_pulses", 64'(done_seen - done_base), 64'(1));
        check("bytes_outstanding", 64'(exp_q.size()), 64'(0));
        check("reads_outstanding", 64'(addr_q.size()), 64'(0));
        check("idle_ready", 64'(start_ready), 64'(1));
        check("idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_base;
        int t;
        for (int i = 0; i < L; i++) mem[i] = W'($urandom());
        mem[5] = 32'h44332211;
        mem[6] = 32'h88776655;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready", 64'(start_ready), 64'(0));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_last", 64'(m_last), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ram_rd_ena", 64'(ram_rd_ena), 64'(0));
        check("rst_ram_addr", 64'(ram_addr), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_ready", 64'(start_ready), 64'(1));

        // Basic: latency and gap-free streaming
        ready_mode = 0;
        start_xfer(5, 8);
        wait_done(200);
        check("first_valid_latency", 64'(first_vld - acc_cyc), 64'(2));
        check("gap_free_span", 64'(last_hs - first_hs), 64'(7));

        // Single word
        start_xfer(5, 4);
        wait_done(200);

        // Partial last word: exactly two reads
        rd_base = rd_seen;
        start_xfer(5, 6);
        wait_done(200);
        check("partial_reads", 64'(rd_seen - rd_base), 64'(2));

        // Backpressure 1,0,0 pattern
        ready_mode = 1;
        start_xfer(5, 8);
        wait_done(400);
        check("bp_byte_count", 64'(hs_xfer), 64'(8));
        ready_mode = 0;

        // Address wrap
        rd_base = rd_seen;
        start_xfer(L - 1, 8);
        wait_done(200);
        check("wrap_reads", 64'(rd_seen - rd_base), 64'(2));

        // Zero length
        rd_base = rd_seen;
        start_xfer(7, 0);
        wait_done(50);
        check("zero_len_reads", 64'(rd_seen - rd_base), 64'(0));
        check("zero_len_bytes", 64'(hs_xfer), 64'(0));

        // Requests while busy are not accepted
        start_xfer(5, 8);
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            start_addr  = '0;
            start_len   = LEN_W'(3);
            check("busy_no_accept", 64'(start_ready), 64'(0));
            @(posedge clk);
            #1;
        end
        start_valid = 1'b0;
        wait_done(200);

        // Reset in the middle of a stream
        start_xfer(5, 8);
        t = 0;
        while (hs_xfer < 2 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (hs_xfer < 2) fail_now("midstream_timeout: bytes not streaming before reset");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        addr_q.delete();
        check("abort_m_valid", 64'(m_valid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_m_last", 64'(m_last), 64'(0));
        check("abort_rd_ena", 64'(ram_rd_ena), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        done_base = done_seen;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_seen - done_base), 64'(0));
        start_xfer(5, 8);
        wait_done(200);

        // Randomized requests and downstream readiness
        for (int n = 0; n < 25; n++) begin
            ready_mode = int'($urandom_range(0, 2));
            start_xfer(int'($urandom_range(0, L - 1)), int'($urandom_range(0, 41)));
            wait_done(2000);
        end
        ready_mode = 0;

        repeat (10) @(posedge clk);
        #1;
        check("final_bytes_outstanding", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
